mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Load/store unit between a request/response handshake and a single-port RAM
// with a combinational read. Byte and half stores are read-modify-write.
module mem_lsu #(
    parameter int RAM_SZ = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        ram_w_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // Highest address where a full 4-byte window still fits in the RAM.
    localparam logic [31:0] MAX_ADDR = 32'(RAM_SZ - 4);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        unsigned_q;
    logic        fault_q;
    logic        accept;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept    = req_valid && req_ready;
    assign req_fault = (req_size == 2'd3) || (req_addr > MAX_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                we_q       <= req_we;
                unsigned_q <= req_unsigned;
                fault_q    <= req_fault;
            end
            if (state == READ) begin
                word_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        load_data = word_q;
        case (size_q)
            2'd0:    load_data = unsigned_q ? {24'h0, word_q[7:0]}
                                            : {{24{word_q[7]}}, word_q[7:0]};
            2'd1:    load_data = unsigned_q ? {16'h0, word_q[15:0]}
                                            : {{16{word_q[15]}}, word_q[15:0]};
            default: load_data = word_q;
        endcase
    end

    // Sub-word stores keep the upper bytes of the word fetched in READ.
    always_comb begin
        merge_data = wdata_q;
        case (size_q)
            2'd0:    merge_data = {word_q[31:8], wdata_q[7:0]};
            2'd1:    merge_data = {word_q[31:16], wdata_q[15:0]};
            default: merge_data = wdata_q;
        endcase
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_fault  = 1'b0;
        ram_w_en   = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_next = RESP;
                    end else if (req_we && req_size == 2'd2) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                ram_addr   = addr_q;
                state_next = we_q ? WRITE : RESP;
            end
            WRITE: begin
                ram_w_en   = 1'b1;
                ram_addr   = addr_q;
                ram_wdata  = merge_data;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = fault_q;
                rsp_rdata = (we_q || fault_q) ? 32'h0 : load_data;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
